// File: rtl/reg16_bus_ctrl.sv
// Bus sequencer driving a downstream dual 8-bit register: byte-enabled latch writes and timed output-enable reads.
// Define REG16_BUS_CTRL_TURNAROUND_EN to add a one-cycle TURN state between a read and the next transaction.
module reg16_bus_ctrl #(
    parameter int OE_CYCLES  = 2,
    parameter int BUSY_LIMIT = 255
) (
    input  logic        CLK,
    input  logic        N_RST,
    input  logic        WR_VALID,
    output logic        WR_READY,
    input  logic [15:0] WR_DATA,
    input  logic [1:0]  WR_BE,
    input  logic [1:0]  RD_REQ,
    output logic        RD_ACK,
    output logic        RD_ERR,
    output logic [7:0]  D1,
    output logic [7:0]  D2,
    output logic        LCLK1,
    output logic        LCLK2,
    output logic        N_OE1,
    output logic        N_OE2
);

    localparam int            PW       = $clog2(BUSY_LIMIT + 2);
    localparam logic [PW-1:0] PEND_MAX = PW'(BUSY_LIMIT + 1);
    localparam logic [PW-1:0] PEND_ONE = PW'(1);
    localparam logic [3:0]    OE_LAST  = 4'(OE_CYCLES - 1);

`ifdef REG16_BUS_CTRL_TURNAROUND_EN
    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, READ, TURN} state_t;
`else
    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, READ} state_t;
`endif

    state_t        state;
    state_t        state_nxt;
    logic [1:0]    be_q;
    logic [1:0]    rd_sel;
    logic [3:0]    oe_cnt;
    logic [PW-1:0] pend_cnt;
    logic          wr_take;
    logic          rd_start;
    logic          rd_pending;

    // A write arriving in IDLE always wins over a waiting read.
    assign wr_take    = (state == IDLE) && WR_VALID && (WR_BE != 2'b00);
    assign rd_start   = (state == IDLE) && !WR_VALID && (RD_REQ != 2'b00);
    assign rd_pending = (RD_REQ != 2'b00) && (state != READ);

    always_ff @(posedge CLK or negedge N_RST) begin
        if (!N_RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        WR_READY  = 1'b0;
        LCLK1     = 1'b0;
        LCLK2     = 1'b0;
        N_OE1     = 1'b1;
        N_OE2     = 1'b1;
        RD_ACK    = 1'b0;
        case (state)
            IDLE: begin
                WR_READY = N_RST;
                if (WR_VALID) begin
                    if (WR_BE != 2'b00) begin
                        state_nxt = SETUP;
                    end
                end else if (RD_REQ != 2'b00) begin
                    state_nxt = READ;
                end
            end
            SETUP:  state_nxt = STROBE;
            STROBE: begin
                LCLK1     = be_q[0];
                LCLK2     = be_q[1];
                state_nxt = HOLD;
            end
            HOLD:   state_nxt = IDLE;
            READ: begin
                N_OE1  = ~rd_sel[0];
                N_OE2  = ~rd_sel[1];
                RD_ACK = (oe_cnt == 4'd0);
                if (oe_cnt == 4'd0) begin
`ifdef REG16_BUS_CTRL_TURNAROUND_EN
                    state_nxt = TURN;
`else
                    state_nxt = IDLE;
`endif
                end
            end
`ifdef REG16_BUS_CTRL_TURNAROUND_EN
            TURN:   state_nxt = IDLE;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // Only enabled bytes are updated, so D1/D2 keep the last value written to each register.
    always_ff @(posedge CLK or negedge N_RST) begin
        if (!N_RST) begin
            be_q <= 2'b00;
            D1   <= 8'h00;
            D2   <= 8'h00;
        end else if (wr_take) begin
            be_q <= WR_BE;
            if (WR_BE[0]) begin
                D1 <= WR_DATA[7:0];
            end
            if (WR_BE[1]) begin
                D2 <= WR_DATA[15:8];
            end
        end
    end

    always_ff @(posedge CLK or negedge N_RST) begin
        if (!N_RST) begin
            rd_sel <= 2'b00;
            oe_cnt <= 4'd0;
        end else if (rd_start) begin
            rd_sel <= RD_REQ;
            oe_cnt <= OE_LAST;
        end else if ((state == READ) && (oe_cnt != 4'd0)) begin
            oe_cnt <= oe_cnt - 4'd1;
        end
    end

    // Starvation watchdog: RD_ERR latches once a request has waited BUSY_LIMIT+1 cycles.
    always_ff @(posedge CLK or negedge N_RST) begin
        if (!N_RST) begin
            pend_cnt <= '0;
            RD_ERR   <= 1'b0;
        end else if (rd_start) begin
            pend_cnt <= '0;
        end else if (rd_pending && (pend_cnt != PEND_MAX)) begin
            pend_cnt <= pend_cnt + PEND_ONE;
            if (pend_cnt + PEND_ONE == PEND_MAX) begin
                RD_ERR <= 1'b1;
            end
        end
    end

endmodule
